// File: rtl/fp_pkg.sv
// Float field layout and loader state encoding, shared by the operand loader and the adder.
package fp_pkg;

    localparam int          SIGN_BIT = 31;
    localparam int          EXP_MSB  = 30;
    localparam int          EXP_LSB  = 25;
    localparam int          MAN_MSB  = 24;
    localparam logic [5:0]  EXP_MAX  = 6'd63;

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t LOAD_A  = 2'd0;
    localparam loader_state_t LOAD_B  = 2'd1;
    localparam loader_state_t PRESENT = 2'd2;

    // Zero ignores the sign: exponent and mantissa together are bits [EXP_MSB:0].
    function automatic logic is_zero(input logic [31:0] word);
        return (word[EXP_MSB:0] == '0);
    endfunction

    function automatic logic is_exp_max(input logic [31:0] word);
        return (word[EXP_MSB:EXP_LSB] == EXP_MAX);
    endfunction

endpackage

// File: rtl/fp_byte_assembler.sv
// Shared MSB-first byte shifter with a 2-bit byte counter and a word-complete pulse.
module fp_byte_assembler
    import fp_pkg::*;
(
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] next_word,
    output logic        word_done
);

    // Only the three most recent bytes are stored; the fourth arrives live on byte_in,
    // so next_word is the full 32-bit shift-register contents after this transfer.
    logic [23:0] held;
    logic [1:0]  count;

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            held  <= '0;
            count <= '0;
        end else if (shift_en) begin
            held  <= next_word[23:0];
            count <= count + 2'd1;
        end
    end

    assign next_word = {held, byte_in};
    assign word_done = shift_en && (count == 2'd3);

endmodule

// File: rtl/fp_operand_loader.sv
// Assembles two float operands from a byte stream and presents them to the adder until ack or timeout.
//   state   | meaning
//   LOAD_A  | accepting the four bytes of operand A
//   LOAD_B  | accepting the four bytes of operand B
//   PRESENT | pair held on the outputs, waiting for op_ack or timer expiry
module fp_operand_loader
    import fp_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    output logic        op_valid,
    input  logic        op_ack,
    output logic [3:0]  flags_out,
    output logic        timeout,
    output logic [1:0]  state_out
);

    localparam int             TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    loader_state_t  state;
    loader_state_t  next_state;
    logic [TW-1:0]  timer;
    logic [31:0]    asm_a;
    logic [23:0]    asm_b;
    logic [31:0]    next_word;
    logic [31:0]    word_b;
    logic           word_done;
    logic           take;
    logic           expired;

    assign take    = byte_valid && byte_ready;
    assign expired = (timer == TIMER_LAST);
    assign word_b  = {asm_b, byte_in};

    fp_byte_assembler u_assembler (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .shift_en     (take),
        .byte_in      (byte_in),
        .next_word    (next_word),
        .word_done    (word_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            LOAD_A:  if (word_done) next_state = LOAD_B;
            LOAD_B:  if (word_done) next_state = PRESENT;
            PRESENT: if (op_ack || expired) next_state = LOAD_A;
            default: next_state = LOAD_A;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state      <= LOAD_A;
            byte_ready <= 1'b0;
            op_valid   <= 1'b0;
            timer      <= '0;
            asm_a      <= '0;
            asm_b      <= '0;
            op_A_out   <= '0;
            op_B_out   <= '0;
            flags_out  <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= next_state;
            byte_ready <= (next_state != PRESENT);
            op_valid   <= (next_state == PRESENT);

            if (take && state == LOAD_A) begin
                asm_a <= next_word;
            end

            if (take && state == LOAD_B) begin
                asm_b <= next_word[23:0];
                if (word_done) begin
                    op_A_out  <= asm_a;
                    op_B_out  <= word_b;
                    flags_out <= {is_exp_max(word_b), is_exp_max(asm_a),
                                  is_zero(word_b),    is_zero(asm_a)};
                    timeout   <= 1'b0;
                    timer     <= '0;
                end
            end

            // Ack has priority over expiry in the same cycle.
            if (state == PRESENT && !op_ack) begin
                if (expired) begin
                    timeout <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader with a short ack timeout.
module tb_fp_operand_loader;

    logic        clock_100kHz = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] op_A_out;
    logic [31:0] op_B_out;
    logic        op_valid;
    logic        op_ack;
    logic [3:0]  flags_out;
    logic        timeout;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    fp_operand_loader #(.ACK_TIMEOUT(4)) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .op_A_out     (op_A_out),
        .op_B_out     (op_B_out),
        .op_valid     (op_valid),
        .op_ack       (op_ack),
        .flags_out    (flags_out),
        .timeout      (timeout),
        .state_out    (state_out)
    );

    always #5 clock_100kHz = ~clock_100kHz;

    // Called and returns at 1 time unit after a rising edge; returns after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(posedge clock_100kHz); #1;
            n++;
        end
        if (!byte_ready) begin
            checks++; errors++;
            $display("FAIL send_byte: byte_ready=%0b after %0d cycles, required 1", byte_ready, n);
        end
        @(posedge clock_100kHz); #1;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
        byte_valid = 1'b0;
    endtask

    task automatic ack_pair();
        op_ack = 1'b1;
        @(posedge clock_100kHz); #1;
        op_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; op_ack = 1'b0;
        #12;
        checks++; if (byte_ready !== 1'b0)    begin errors++; $display("FAIL reset_byte_ready got %b want 0", byte_ready); end
        checks++; if (op_A_out !== 32'h0)     begin errors++; $display("FAIL reset_op_A got %h want 0", op_A_out); end
        checks++; if (op_B_out !== 32'h0)     begin errors++; $display("FAIL reset_op_B got %h want 0", op_B_out); end
        checks++; if (op_valid !== 1'b0)      begin errors++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
        checks++; if (flags_out !== 4'h0)     begin errors++; $display("FAIL reset_flags got %b want 0000", flags_out); end
        checks++; if (timeout !== 1'b0)       begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
        checks++; if (state_out !== 2'd0)     begin errors++; $display("FAIL reset_state got %0d want 0", state_out); end
        @(negedge clock_100kHz); reset = 1'b1;
        @(posedge clock_100kHz); #1;
    endtask

    task automatic test_pair_load();
        send_pair(32'h3F800000, 32'h40000000);
        checks++; if (op_valid !== 1'b1)          begin errors++; $display("FAIL load_op_valid got %b want 1", op_valid); end
        checks++; if (op_A_out !== 32'h3F800000)  begin errors++; $display("FAIL load_op_A got %h want 3f800000", op_A_out); end
        checks++; if (op_B_out !== 32'h40000000)  begin errors++; $display("FAIL load_op_B got %h want 40000000", op_B_out); end
        checks++; if (flags_out !== 4'b0000)      begin errors++; $display("FAIL load_flags got %b want 0000", flags_out); end
        checks++; if (state_out !== 2'd2)         begin errors++; $display("FAIL load_state got %0d want 2", state_out); end
        checks++; if (byte_ready !== 1'b0)        begin errors++; $display("FAIL load_byte_ready got %b want 0", byte_ready); end
        ack_pair();
        checks++; if (op_valid !== 1'b0)          begin errors++; $display("FAIL ack_op_valid got %b want 0", op_valid); end
        checks++; if (byte_ready !== 1'b1)        begin errors++; $display("FAIL ack_byte_ready got %b want 1", byte_ready); end
        checks++; if (state_out !== 2'd0)         begin errors++; $display("FAIL ack_state got %0d want 0", state_out); end
        checks++; if (timeout !== 1'b0)           begin errors++; $display("FAIL ack_timeout got %b want 0", timeout); end
        checks++; if (op_A_out !== 32'h3F800000)  begin errors++; $display("FAIL ack_hold_op_A got %h want 3f800000", op_A_out); end
    endtask

    task automatic test_classification();
        send_pair(32'h00000000, 32'h7E000000);
        checks++; if (flags_out !== 4'b1001) begin errors++; $display("FAIL class_zero_expmax got %b want 1001", flags_out); end
        ack_pair();
        send_pair(32'hFE000000, 32'h80000001);
        checks++; if (flags_out !== 4'b0100) begin errors++; $display("FAIL class_a_expmax got %b want 0100", flags_out); end
        ack_pair();
        send_pair(32'h80000000, 32'h00000000);
        checks++; if (flags_out !== 4'b0011) begin errors++; $display("FAIL class_negzero got %b want 0011", flags_out); end
        ack_pair();
    endtask

    task automatic test_backpressure();
        send_pair(32'h01020304, 32'h05060708);
        byte_in = 8'h11; byte_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock_100kHz); #1;
            checks++; if (byte_ready !== 1'b0)         begin errors++; $display("FAIL bp_byte_ready got %b want 0", byte_ready); end
            checks++; if (op_A_out !== 32'h01020304)   begin errors++; $display("FAIL bp_hold_op_A got %h want 01020304", op_A_out); end
        end
        ack_pair();
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_ack got %b want 1", byte_ready); end
        send_pair(32'h11223344, 32'h55667788);
        checks++; if (op_A_out !== 32'h11223344) begin errors++; $display("FAIL bp_op_A got %h want 11223344", op_A_out); end
        checks++; if (op_B_out !== 32'h55667788) begin errors++; $display("FAIL bp_op_B got %h want 55667788", op_B_out); end
        ack_pair();
    endtask

    task automatic test_timeout();
        int n;
        send_pair(32'h12345678, 32'h9ABCDEF0);
        n = op_valid ? 1 : 0;
        while (op_valid && n < 20) begin
            @(posedge clock_100kHz); #1;
            if (op_valid) n++;
        end
        checks++; if (n !== 4)              begin errors++; $display("FAIL to_valid_cycles got %0d want 4", n); end
        checks++; if (timeout !== 1'b1)     begin errors++; $display("FAIL to_timeout got %b want 1", timeout); end
        checks++; if (byte_ready !== 1'b1)  begin errors++; $display("FAIL to_byte_ready got %b want 1", byte_ready); end
        checks++; if (state_out !== 2'd0)   begin errors++; $display("FAIL to_state got %0d want 0", state_out); end
        checks++; if (op_B_out !== 32'h9ABCDEF0) begin errors++; $display("FAIL to_hold_op_B got %h want 9abcdef0", op_B_out); end
        send_pair(32'h3F800000, 32'h3F800000);
        checks++; if (timeout !== 1'b0)     begin errors++; $display("FAIL to_clear got %b want 0", timeout); end
        checks++; if (op_valid !== 1'b1)    begin errors++; $display("FAIL to_next_valid got %b want 1", op_valid); end
        ack_pair();
    endtask

    task automatic test_simultaneous();
        send_pair(32'hC0000000, 32'h41200000);
        repeat (3) begin @(posedge clock_100kHz); #1; end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL sim_still_valid got %b want 1", op_valid); end
        ack_pair();
        checks++; if (op_valid !== 1'b0)  begin errors++; $display("FAIL sim_op_valid got %b want 0", op_valid); end
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL sim_timeout got %b want 0", timeout); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL sim_state got %0d want 0", state_out); end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        byte_valid = 1'b0;
        reset = 1'b0;
        #2;
        checks++; if (op_A_out !== 32'h0)  begin errors++; $display("FAIL mid_op_A got %h want 0", op_A_out); end
        checks++; if (op_B_out !== 32'h0)  begin errors++; $display("FAIL mid_op_B got %h want 0", op_B_out); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_byte_ready got %b want 0", byte_ready); end
        checks++; if (state_out !== 2'd0)  begin errors++; $display("FAIL mid_state got %0d want 0", state_out); end
        @(negedge clock_100kHz); reset = 1'b1;
        @(posedge clock_100kHz); #1;
        send_pair(32'hAABBCCDD, 32'hEEFF1234);
        checks++; if (op_A_out !== 32'hAABBCCDD) begin errors++; $display("FAIL mid_fresh_op_A got %h want aabbccdd", op_A_out); end
        checks++; if (op_B_out !== 32'hEEFF1234) begin errors++; $display("FAIL mid_fresh_op_B got %h want eeff1234", op_B_out); end
        checks++; if (op_valid !== 1'b1)         begin errors++; $display("FAIL mid_fresh_valid got %b want 1", op_valid); end
        ack_pair();
    endtask

    initial begin
        test_reset();
        test_pair_load();
        test_classification();
        test_backpressure();
        test_timeout();
        test_simultaneous();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
